// File: rtl/cache_refill_arbiter.sv
// Arbitrates I-cache and D-cache block refills onto one 64-bit memory bus and
// streams the returned beats into the owning cache's fill port.
module cache_refill_arbiter #(
  parameter int unsigned B = 8,
  parameter int unsigned b = 3,
  parameter int unsigned y = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_miss,
  input  logic [63:0]   if_addr,
  input  logic          d_miss,
  input  logic [63:0]   d_addr,
  output logic          bus_req_valid,
  output logic [63:0]   bus_req_addr,
  input  logic          bus_req_ready,
  input  logic          bus_resp_valid,
  input  logic [63:0]   bus_resp_data,
  output logic          fill_valid,
  output logic          fill_sel,
  output logic [b-1:0]  fill_idx,
  output logic [63:0]   fill_data,
  output logic          fill_done_i,
  output logic          fill_done_d,
  output logic          bus_err
);

  localparam int unsigned OFF      = b + y;
  localparam logic [63:0] BLK_MASK = ~((64'd1 << OFF) - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_BEAT,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_grant_q, last_grant_d;
  logic [63:0]    addr_q, addr_d;
  logic [b-1:0]   cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           grant;
  logic [63:0]    sel_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    grant         = 1'b0;
    sel_addr      = '0;
    bus_req_valid = 1'b0;
    fill_valid    = 1'b0;
    fill_data     = '0;
    fill_done_i   = 1'b0;
    fill_done_d   = 1'b0;
    // Beats outside BEAT are dropped but remembered until reset.
    err_d         = err_q | (bus_resp_valid && (state_q != S_BEAT));

    case (state_q)
      S_IDLE: begin
        if (if_miss || d_miss) begin
          grant        = (if_miss && d_miss) ? ~last_grant_q : d_miss;
          sel_addr     = grant ? d_addr : if_addr;
          owner_d      = grant;
          last_grant_d = grant;
          addr_d       = sel_addr & BLK_MASK;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        bus_req_valid = 1'b1;
        if (bus_req_ready) begin
          cnt_d   = '0;
          state_d = S_BEAT;
        end
      end
      S_BEAT: begin
        if (bus_resp_valid) begin
          fill_valid = 1'b1;
          fill_data  = bus_resp_data;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == b'(B - 1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        fill_done_i = ~owner_q;
        fill_done_d = owner_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus_req_addr = addr_q;
  assign fill_sel     = owner_q;
  assign fill_idx     = cnt_q;
  assign bus_err      = err_q;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed self-checking bench for cache_refill_arbiter.
module tb_cache_refill_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_miss, d_miss;
  logic [63:0] if_addr, d_addr;
  logic        bus_req_valid, bus_req_ready;
  logic [63:0] bus_req_addr;
  logic        bus_resp_valid;
  logic [63:0] bus_resp_data;
  logic        fill_valid, fill_sel, fill_done_i, fill_done_d, bus_err;
  logic [2:0]  fill_idx;
  logic [63:0] fill_data;

  int checks = 0;
  int errors = 0;

  cache_refill_arbiter #(.B(8), .b(3), .y(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_miss        (if_miss),
    .if_addr        (if_addr),
    .d_miss         (d_miss),
    .d_addr         (d_addr),
    .bus_req_valid  (bus_req_valid),
    .bus_req_addr   (bus_req_addr),
    .bus_req_ready  (bus_req_ready),
    .bus_resp_valid (bus_resp_valid),
    .bus_resp_data  (bus_resp_data),
    .fill_valid     (fill_valid),
    .fill_sel       (fill_sel),
    .fill_idx       (fill_idx),
    .fill_data      (fill_data),
    .fill_done_i    (fill_done_i),
    .fill_done_d    (fill_done_d),
    .bus_err        (bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat_word(input logic o, input int unsigned k);
    return 64'hC0DE_0000_0000_0000 | (64'(o) << 8) | 64'(k);
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_valid"}, bus_req_valid, 1'b0);
    chk({tag, "_req_addr"},  bus_req_addr, 64'd0);
    chk({tag, "_fill_valid"}, fill_valid, 1'b0);
    chk({tag, "_fill_idx"},  fill_idx, 3'd0);
    chk({tag, "_fill_sel"},  fill_sel, 1'b0);
    chk({tag, "_fill_data"}, fill_data, 64'd0);
    chk({tag, "_done_i"},    fill_done_i, 1'b0);
    chk({tag, "_done_d"},    fill_done_d, 1'b0);
    chk({tag, "_bus_err"},   bus_err, 1'b0);
  endtask

  // Entered one cycle after the grant edge (DUT in REQ).
  task automatic do_req(input logic owner, input logic [63:0] exp_addr, input int unsigned wait_cyc);
    for (int unsigned i = 0; i < wait_cyc; i++) begin
      bus_req_ready = 1'b0;
      #1;
      chk("req_valid_wait", bus_req_valid, 1'b1);
      chk("req_addr_wait", bus_req_addr, exp_addr);
      chk("req_nofill_wait", fill_valid, 1'b0);
      tick();
    end
    bus_req_ready = 1'b1;
    #1;
    chk("req_valid", bus_req_valid, 1'b1);
    chk("req_addr", bus_req_addr, exp_addr);
    chk("req_sel", fill_sel, owner);
    tick();
    bus_req_ready = 1'b0;
  endtask

  // Bit n of gap = resp_valid on cycle n; all-valid once the pattern runs out.
  task automatic do_beats(input logic owner, input logic [15:0] gap);
    int unsigned k = 0;
    int unsigned cyc = 0;
    logic v;
    while (k < 8) begin
      v = (cyc < 16) ? gap[cyc] : 1'b1;
      bus_resp_valid = v;
      bus_resp_data  = beat_word(owner, cyc);
      #1;
      chk("beat_fill_valid", fill_valid, v);
      chk("beat_req_valid", bus_req_valid, 1'b0);
      if (v) begin
        chk("beat_idx", fill_idx, 3'(k));
        chk("beat_data", fill_data, beat_word(owner, cyc));
        chk("beat_sel", fill_sel, owner);
        k++;
      end
      chk("beat_no_done", fill_done_i | fill_done_d, 1'b0);
      tick();
      cyc++;
    end
    bus_resp_valid = 1'b0;
    bus_resp_data  = '0;
    #1;
    chk("done_i", fill_done_i, !owner);
    chk("done_d", fill_done_d, owner);
    chk("done_fill_valid", fill_valid, 1'b0);
  endtask

  task automatic refill(input logic owner, input logic [63:0] exp_addr,
                        input int unsigned wait_cyc, input logic [15:0] gap);
    do_req(owner, exp_addr, wait_cyc);
    do_beats(owner, gap);
    if (owner) d_miss = 1'b0;
    else       if_miss = 1'b0;
    tick();
    #1;
    chk("post_done_i", fill_done_i, 1'b0);
    chk("post_done_d", fill_done_d, 1'b0);
    chk("post_req_valid", bus_req_valid, 1'b0);
  endtask

  initial begin
    rst_n          = 1'b0;
    if_miss        = 1'b0;
    d_miss         = 1'b0;
    if_addr        = '0;
    d_addr         = '0;
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b0;
    bus_resp_data  = '0;
    #3;
    chk_idle_outputs("reset");
    #9;
    rst_n = 1'b1;
    tick();

    // 1: single I-cache miss
    if_miss = 1'b1;
    if_addr = 64'h1234;
    tick();
    refill(1'b0, 64'h1200, 0, 16'hFFFF);

    // 2: simultaneous misses after reset alternate I, D, I, D
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("reset2");
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if_miss = 1'b1;
      d_miss  = 1'b1;
      if_addr = 64'h0000_0000_0040_1234;
      d_addr  = 64'hDEAD_BEEF_0000_0FFF;
      tick();
      if (i % 2 == 0) refill(1'b0, 64'h0000_0000_0040_1200, 0, 16'hFFFF);
      else            refill(1'b1, 64'hDEAD_BEEF_0000_0FC0, 0, 16'hFFFF);
    end
    if_miss = 1'b0;
    d_miss  = 1'b0;

    // 3: request held off by bus_req_ready for 5 cycles
    d_miss = 1'b1;
    d_addr = 64'h807F;
    tick();
    refill(1'b1, 64'h8040, 5, 16'hFFFF);

    // 4: gaps in bus_resp_valid
    if_miss = 1'b1;
    if_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    refill(1'b0, 64'hFFFF_FFFF_FFFF_FFC0, 0, 16'b1101_0110_1010_1001);
    chk("err_clean", bus_err, 1'b0);

    // 5: reset after three beats abandons the refill
    d_miss = 1'b1;
    d_addr = 64'h1_0000;
    tick();
    do_req(1'b1, 64'h1_0000, 0);
    for (int k = 0; k < 3; k++) begin
      bus_resp_valid = 1'b1;
      bus_resp_data  = beat_word(1'b1, k);
      tick();
    end
    bus_resp_data = beat_word(1'b1, 3);
    #1;
    chk("pre_rst_fill_valid", fill_valid, 1'b1);
    chk("pre_rst_idx", fill_idx, 3'd3);
    rst_n          = 1'b0;
    bus_resp_valid = 1'b0;
    bus_resp_data  = '0;
    #1;
    chk_idle_outputs("midrst");
    tick();
    chk("midrst_no_done_d", fill_done_d, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rel_no_done_d", fill_done_d, 1'b0);
    tick();
    refill(1'b1, 64'h1_0000, 0, 16'hFFFF);

    // 6: response beat while idle sets a sticky error
    bus_resp_valid = 1'b1;
    bus_resp_data  = 64'h5555;
    #1;
    chk("idle_resp_fill_valid", fill_valid, 1'b0);
    chk("idle_resp_err_before", bus_err, 1'b0);
    tick();
    bus_resp_valid = 1'b0;
    #1;
    chk("idle_resp_err", bus_err, 1'b1);
    if_miss = 1'b1;
    if_addr = 64'h2010;
    tick();
    refill(1'b0, 64'h2000, 0, 16'hFFFF);
    chk("err_sticky", bus_err, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("err_cleared", bus_err, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
